// File: rtl/equiv_monitor_pkg.sv
// rtl/equiv_monitor_pkg.sv - shared types, defaults and helpers for equiv_monitor
//
// Contents:
//   state_e    : monitor FSM state (IDLE=0, MATCH=1, PEND=2, FAIL=3)
//   DEF_*      : default parameter values for the monitor
//   sat_inc()  : increment that sticks at the all-ones value of a given width
package equiv_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_PEND  = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_TOL   = 0;
  localparam int DEF_TS_W  = 32;

  // Operates on a 64-bit container so one function serves every counter
  // width; w must be in 1..64.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = ~64'd0 >> (64 - w);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/equiv_sat_counter.sv
// rtl/equiv_sat_counter.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clk   in       clock, rising edge
//   rst_n in       asynchronous active-low reset
//   inc   in       increment request (ignored once all-ones is reached)
//   clr   in       synchronous clear, wins over inc
//   cnt   out [W]  current count
module equiv_sat_counter
  import equiv_monitor_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = W'(sat_inc(64'(cnt_q), W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/equiv_monitor.sv
// rtl/equiv_monitor.sv - hardware iff-equivalence monitor for a pair of 1-bit signals
//
// Optional feature macro: EQUIV_MONITOR_TSTAMP_EN (free-running cycle counter
// and first-failure timestamp; when undefined first_fail_ts is tied to 0).
//
// Ports:
//   clk           in            sampling clock, rising edge
//   rst_n         in            asynchronous active-low reset
//   en            in            sampling enable
//   clr           in            synchronous clear of results (beats a sample)
//   sig_a, sig_b  in            signals checked for equivalence
//   pass_pulse    out           one-cycle pulse per equivalent sample
//   fail_pulse    out           one-cycle pulse per declared failure
//   err_sticky    out           set on first failure, held until clr/reset
//   pass_cnt      out [CNT_W]   saturating count of passing samples
//   fail_cnt      out [CNT_W]   saturating count of failing samples
//   mismatch_run  out [CNT_W]   current consecutive-mismatch length
//   state         out [2]       FSM state (IDLE/MATCH/PEND/FAIL)
//   first_fail_ts out [TS_W]    cycle stamp of first failure
module equiv_monitor
  import equiv_monitor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TOL   = DEF_TOL,
  parameter int TS_W  = DEF_TS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             sig_a,
  input  logic             sig_b,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] mismatch_run,
  output logic [1:0]       state,
  output logic [TS_W-1:0]  first_fail_ts
);

  localparam logic [63:0] TOL_L = 64'(TOL);

  logic   sample;
  logic   eq;
  logic   over_tol;
  logic   pass_d, fail_d, mism_d, run_clr;
  logic   err_sticky_d;
  state_e state_d;

  logic   pass_pulse_q, fail_pulse_q, err_sticky_q;
  state_e state_q;

  // clr discards any sample taken on the same edge.
  assign sample   = en & ~clr;
  assign eq       = (sig_a == sig_b);
  assign over_tol = (64'(mismatch_run) >= TOL_L);

  always_comb begin
    pass_d       = sample & eq;
    mism_d       = sample & ~eq;
    fail_d       = mism_d & over_tol;
    run_clr      = clr | ~en | pass_d;
    err_sticky_d = clr ? 1'b0 : (err_sticky_q | fail_d);
    state_d      = state_q;
    if (clr || !en) begin
      state_d = ST_IDLE;
    end else if (eq) begin
      state_d = ST_MATCH;
    end else if (over_tol) begin
      state_d = ST_FAIL;
    end else begin
      state_d = ST_PEND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pass_pulse_q <= 1'b0;
      fail_pulse_q <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pass_pulse_q <= pass_d;
      fail_pulse_q <= fail_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  equiv_sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (pass_d),
    .clr  (clr),
    .cnt  (pass_cnt)
  );

  equiv_sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (fail_d),
    .clr  (clr),
    .cnt  (fail_cnt)
  );

  // The run length restarts on any equivalent sample or when sampling stops.
  equiv_sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (mism_d),
    .clr  (run_clr),
    .cnt  (mismatch_run)
  );

`ifdef EQUIV_MONITOR_TSTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] first_fail_ts_q, first_fail_ts_d;

  always_comb begin
    ts_d            = ts_q + 1'b1;
    first_fail_ts_d = first_fail_ts_q;
    if (clr) begin
      first_fail_ts_d = '0;
    end else if (fail_d && !err_sticky_q) begin
      // err_sticky low means this is the first failure since reset/clr.
      first_fail_ts_d = ts_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q            <= '0;
      first_fail_ts_q <= '0;
    end else begin
      ts_q            <= ts_d;
      first_fail_ts_q <= first_fail_ts_d;
    end
  end

  assign first_fail_ts = first_fail_ts_q;
`else
  assign first_fail_ts = '0;
`endif

  assign pass_pulse = pass_pulse_q;
  assign fail_pulse = fail_pulse_q;
  assign err_sticky = err_sticky_q;
  assign state      = state_q;

endmodule

// File: tb/tb_equiv_monitor.sv
// tb/tb_equiv_monitor.sv - self-checking bench for equiv_monitor (three parameterisations)
module tb_equiv_monitor;

  logic clk;
  logic rst_n;
  logic en, clr, sig_a, sig_b;

  // Instance 0: TOL=0 CNT_W=16; 1: TOL=2 CNT_W=16; 2: TOL=0 CNT_W=2
  logic        pp0, fp0, er0, pp1, fp1, er1, pp2, fp2, er2;
  logic [15:0] pc0, fc0, rn0, pc1, fc1, rn1;
  logic [1:0]  pc2, fc2, rn2;
  logic [1:0]  st0, st1, st2;
  logic [31:0] ts0, ts1, ts2;

  equiv_monitor #(.CNT_W(16), .TOL(0), .TS_W(32)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .sig_a(sig_a), .sig_b(sig_b),
    .pass_pulse(pp0), .fail_pulse(fp0), .err_sticky(er0), .pass_cnt(pc0),
    .fail_cnt(fc0), .mismatch_run(rn0), .state(st0), .first_fail_ts(ts0)
  );
  equiv_monitor #(.CNT_W(16), .TOL(2), .TS_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .sig_a(sig_a), .sig_b(sig_b),
    .pass_pulse(pp1), .fail_pulse(fp1), .err_sticky(er1), .pass_cnt(pc1),
    .fail_cnt(fc1), .mismatch_run(rn1), .state(st1), .first_fail_ts(ts1)
  );
  equiv_monitor #(.CNT_W(2), .TOL(0), .TS_W(32)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .sig_a(sig_a), .sig_b(sig_b),
    .pass_pulse(pp2), .fail_pulse(fp2), .err_sticky(er2), .pass_cnt(pc2),
    .fail_cnt(fc2), .mismatch_run(rn2), .state(st2), .first_fail_ts(ts2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one entry per instance, plain integer bookkeeping.
  int          tolv [3] = '{0, 2, 0};
  int          maxv [3] = '{65535, 65535, 3};
  int          m_pass [3];
  int          m_fail [3];
  int          m_run  [3];
  int          m_st   [3];   // 0 idle, 1 match, 2 pend, 3 fail
  bit          m_pp   [3];
  bit          m_fp   [3];
  bit          m_err  [3];
  logic [31:0] m_cap  [3];
  logic [31:0] m_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pass[k] = 0; m_fail[k] = 0; m_run[k] = 0; m_st[k] = 0;
      m_pp[k] = 0; m_fp[k] = 0; m_err[k] = 0; m_cap[k] = 0;
    end
    m_cyc = 0;
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      m_pp[k] = 0;
      m_fp[k] = 0;
      if (clr) begin
        m_pass[k] = 0; m_fail[k] = 0; m_run[k] = 0; m_err[k] = 0;
        m_cap[k] = 0; m_st[k] = 0;
      end else if (!en) begin
        m_run[k] = 0; m_st[k] = 0;
      end else if (sig_a == sig_b) begin
        m_pp[k] = 1;
        if (m_pass[k] < maxv[k]) m_pass[k]++;
        m_run[k] = 0; m_st[k] = 1;
      end else if (m_run[k] < tolv[k]) begin
        if (m_run[k] < maxv[k]) m_run[k]++;
        m_st[k] = 2;
      end else begin
        m_fp[k] = 1;
        if (m_fail[k] < maxv[k]) m_fail[k]++;
        if (m_run[k] < maxv[k]) m_run[k]++;
        if (!m_err[k]) m_cap[k] = m_cyc;
        m_err[k] = 1;
        m_st[k] = 3;
      end
    end
    m_cyc = m_cyc + 32'd1;
  endtask

  task automatic check_inst(input int k, input logic pp, input logic fp, input logic er,
                            input logic [63:0] pc, input logic [63:0] fc, input logic [63:0] rn,
                            input logic [1:0] st, input logic [31:0] ts);
    logic [31:0] exp_ts;
`ifdef EQUIV_MONITOR_TSTAMP_EN
    exp_ts = m_cap[k];
`else
    exp_ts = 32'd0;
`endif
    check($sformatf("u%0d.pass_pulse", k), 64'(pp), 64'(m_pp[k]));
    check($sformatf("u%0d.fail_pulse", k), 64'(fp), 64'(m_fp[k]));
    check($sformatf("u%0d.err_sticky", k), 64'(er), 64'(m_err[k]));
    check($sformatf("u%0d.pass_cnt", k), pc, 64'(m_pass[k]));
    check($sformatf("u%0d.fail_cnt", k), fc, 64'(m_fail[k]));
    check($sformatf("u%0d.mismatch_run", k), rn, 64'(m_run[k]));
    check($sformatf("u%0d.state", k), 64'(st), 64'(m_st[k]));
    check($sformatf("u%0d.first_fail_ts", k), 64'(ts), 64'(exp_ts));
  endtask

  task automatic check_all();
    check_inst(0, pp0, fp0, er0, 64'(pc0), 64'(fc0), 64'(rn0), st0, ts0);
    check_inst(1, pp1, fp1, er1, 64'(pc1), 64'(fc1), 64'(rn1), st1, ts1);
    check_inst(2, pp2, fp2, er2, 64'(pc2), 64'(fc2), 64'(rn2), st2, ts2);
  endtask

  task automatic cycle(input logic e, input logic c, input logic a, input logic b);
    en = e; clr = c; sig_a = a; sig_b = b;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Asserts reset between edges, checks the asynchronous clear, then releases.
  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; clr = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic mode;
    rst_n = 1'b1;
    en = 1'b0; clr = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Strict check, first samples
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("plan.pass_cnt2", 64'(pc0), 64'd2);
    check("plan.state_match", 64'(st0), 64'd1);

    // Strict mismatch then recovery (u1 walks through PEND here)
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    check("plan.fail_cnt2", 64'(fc0), 64'd2);
    cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 1);
    check("plan.err_held", 64'(er0), 64'd1);

    // Tolerance: three mismatches then a match
    cycle(1, 0, 0, 1);
    check("plan.tol_pend1", 64'(st1), 64'd2);
    cycle(1, 0, 0, 1);
    check("plan.tol_run2", 64'(rn1), 64'd2);
    cycle(1, 0, 0, 1);
    check("plan.tol_fail", 64'(fp1), 64'd1);
    cycle(1, 0, 1, 1);
    check("plan.tol_fail_cnt", 64'(fc1), 64'd1);

    // Clear wins over a same-edge mismatch
    cycle(1, 0, 1, 0);
    cycle(1, 1, 1, 0);
    check("plan.clr_err", 64'(er0), 64'd0);
    check("plan.clr_fail_pulse", 64'(fp0), 64'd0);

    // Disable: run clears, counters hold
    cycle(1, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);

    // Saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 1);
    check("plan.sat_pass", 64'(pc2), 64'd3);

    // Timestamp: first failure on cycle 7 after reset, later failure leaves it
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
`ifdef EQUIV_MONITOR_TSTAMP_EN
    check("plan.first_fail_ts", 64'(ts0), 64'd7);
`endif
    cycle(1, 0, 0, 1);

    // Async reset in the middle of FAIL, between edges
    #3;
    do_reset();

    // Randomised traffic with mismatch bursts, rare clears and idles
    mode = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic a;
      if ($urandom_range(0, 3) == 0) mode = ~mode;
      a = 1'($urandom);
      cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 29) == 0), a, mode ? ~a : a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/equiv_monitor.md
Name: equiv_monitor

Overview:
- Synthesizable equivalence monitor that consumes a pair of 1-bit signals and checks, on every rising clock edge, that they are logically equivalent (a iff b).
- Sits downstream of any dual-signal source: lockstep pairs, redundant flags, DUT vs. reference model.
- Provides per-sample pass/fail pulses, saturating pass/fail counters and a sticky error flag.
- Mirrors the concurrent iff-assertion checks in hardware, so results are visible on silicon/FPGA and in waveforms without simulator assertion support.

Parameters:
- CNT_W, 16: width of pass_cnt, fail_cnt and mismatch_run.
- TOL, 0: consecutive mismatching samples tolerated before a failure is declared. 0 = strict iff, every mismatch fails.
- TS_W, 32: width of the cycle timestamp (used only with the optional feature).

Ports:
- clk  in  1  sampling clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  sampling enable.
- clr  in  1  synchronous clear of results.
- sig_a  in  1  first checked signal.
- sig_b  in  1  second checked signal.
- pass_pulse  out  1  one-cycle pulse: equivalent sample.
- fail_pulse  out  1  one-cycle pulse: declared failure.
- err_sticky  out  1  set on first failure, held until clr or reset.
- pass_cnt  out  CNT_W  count of passing samples.
- fail_cnt  out  CNT_W  count of failing samples.
- mismatch_run  out  CNT_W  current consecutive-mismatch length.
- state  out  2  FSM state encoding.
- first_fail_ts  out  TS_W  cycle stamp of first failure.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: all outputs and registers go to 0 immediately, asynchronously. state = IDLE.
- Sampling: a sample occurs on a rising clk edge with en=1 and clr=0. eq = (sig_a == sig_b). Inputs are 2-state.
- Latency: all outputs are registered. The result of the sample taken at edge N is visible after edge N.
- Pass: eq=1 gives pass_pulse=1 for one cycle, pass_cnt+1, mismatch_run=0.
- Mismatch within tolerance: eq=0 with prior mismatch_run < TOL.
  - mismatch_run+1.
  - No pulse, no counter change.
- Failure: eq=0 with prior mismatch_run >= TOL.
  - fail_pulse=1, fail_cnt+1, err_sticky=1.
  - mismatch_run+1, saturating.
  - Every further mismatching sample in the same run also fails.
- Counters saturate at all-ones; they never wrap.
- FSM states (2-bit, encoded 0..3):
  - IDLE (0): en=0, or after reset/clr.
  - MATCH (1): last sample equivalent.
  - PEND (2): mismatch run within tolerance.
  - FAIL (3): last sample declared a failure.
- FSM transitions:
  - From any state, a sample with eq=1 goes to MATCH.
  - eq=0 within tolerance goes to PEND.
  - eq=0 at or beyond tolerance goes to FAIL.
  - en=0 goes to IDLE and clears mismatch_run; counters and err_sticky hold.
- clr: zeroes counters, mismatch_run, err_sticky and first_fail_ts, and sets state to IDLE. clr has priority over a sample in the same cycle; that sample is discarded and produces no pulse.
- With TOL=0, PEND is unreachable.
- Pulses are 0 whenever no sample occurs.

Optional Feature:
- Macro: EQUIV_MONITOR_TSTAMP_EN.
- Defined:
  - A TS_W free-running cycle counter starts at 0 on reset and increments every clk edge; it wraps.
  - first_fail_ts captures the counter value at the sample edge of the first failure after reset/clr.
  - Later failures do not overwrite it.
- Undefined: no counter is built and first_fail_ts is tied to 0.

Decomposition:
- Package equiv_monitor_pkg holds:
  - state enum typedef (IDLE, MATCH, PEND, FAIL as 2-bit values 0..3);
  - default parameter constants;
  - a saturating-increment function.
- Sub-module equiv_sat_counter (width param, inc, clr, saturating). Instantiated three times: pass, fail, run.

Test Plan:
- Strict check, first samples: TOL=0, en=1, sig_a=0, sig_b=0 for 2 samples -> 2 pass_pulse, pass_cnt=2, state=MATCH, err_sticky=0.
- Strict check, mismatch: TOL=0, sig_a=1, sig_b=0 for 2 samples, then sig_b=1 for 3 samples -> fail_cnt=2, err_sticky=1, then pass_cnt+3, state=MATCH; err_sticky stays 1.
- Tolerance: TOL=2, 3 consecutive mismatches then a match -> no fail_pulse on samples 1-2 (state=PEND, mismatch_run=1,2), fail_pulse on sample 3, fail_cnt=1, match returns mismatch_run=0.
- Clear priority: clr=1 on the same edge as a mismatch with err_sticky=1 -> all counters 0, err_sticky=0, state=IDLE, no fail_pulse.
- Saturation: CNT_W=2, 5 passing samples -> pass_cnt=3 held.
- Async reset: rst_n=0 mid-FAIL, between clock edges -> all outputs 0 before the next edge. With EQUIV_MONITOR_TSTAMP_EN, the first failure at cycle 7 gives first_fail_ts=7, unchanged by a later failure.
